main_fsm: RTL and testbench
===========================

// Module: main_fsm
// PURPOSE
//  Multicycle RV32I main controller. Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction.
//  Drives the datapath muxes and write enables, and produces ALUOp for the downstream aludec stage.
//  Stalls on memory through a single ready handshake.
//  Supported: lw, sw, R-type, I-type ALU, beq/bne, jal.
// PARAMETERS
//  STATE_W       4  width of state register (11 states used)
//  USE_MEM_READY 1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high; forces state to FETCH
//  op         in   7  instruction opcode, from IR
//  funct3     in   3  instruction funct3 (branch sense)
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes this cycle
//  PCWrite    out  1  PC register enable
//  AdrSrc     out  1  0: PC, 1: Result drives memory address
//  MemWrite   out  1  data memory write strobe
//  IRWrite    out  1  IR / OldPC enable
//  ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 RD1
//  ALUSrcB    out  2  00 RD2, 01 ImmExt, 10 constant 4
//  RegWrite   out  1  register file write enable
//  ImmSrc     out  2  00 I, 01 S, 10 B, 11 J
//  ALUOp      out  2  00 add, 01 sub, 10 funct-decoded (to aludec)
//  illegal_op out  1  one-cycle pulse on unsupported opcode/funct3
// BEHAVIOUR
//  - Moore outputs decoded from state; unlisted outputs are 0.
//  - rdy = mem_ready | ~USE_MEM_READY.
//  - State actions and next state:
//      FETCH:    AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=rdy, PCUpdate=rdy.
//                Go to DECODE if rdy, else stay.
//      DECODE:   ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
//                op 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//                1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH with illegal_op=1.
//      MEMADR:   ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD (op[5]=0) or MEMWRITE (op[5]=1).
//      MEMREAD:  AdrSrc=1, ResultSrc=00. Go to MEMWB on rdy.
//      MEMWB:    ResultSrc=01, RegWrite=1. Go to FETCH.
//      MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until rdy. Go to FETCH on rdy.
//      EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
//      EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
//      JAL:      ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
//      ALUWB:    ResultSrc=00, RegWrite=1. Go to FETCH.
//      BRANCH:   ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
//  - PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])).
//  - Branch with funct3 other than 000/001: no branch is taken.
//    illegal_op pulses in DECODE for that case; the branch still runs through BRANCH.
//  - ImmSrc is combinational from op, valid in every state:
//    0100011 -> 01; 1100011 -> 10; 1101111 -> 11; otherwise 00.
//  - Reset (async): state=FETCH immediately, including mid-instruction.
//    MemWrite and RegWrite drop at once; no partial write completes after reset rises.
//    While reset is high, outputs equal FETCH decode.
//  - Latency in cycles, no stalls: lw 5; sw, R, I, jal 4; branch 3.
//    Each rdy=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
//  - Unused state encodings recover to FETCH on the next edge.
// STRUCTURE
//  - Shared include riscv_defs.vh holds:
//      opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL;
//      ALUOp codes; ResultSrc/ALUSrcA/ALUSrcB mux codes; state localparams.
//  - One sub-module, imm_src_dec (op -> ImmSrc).
//  - State register, next-state logic and output decode stay in main_fsm.
// TESTING
//  - Reset mid-MEMWRITE with MemWrite=1 -> MemWrite=0 same cycle; state=FETCH; PCWrite=IRWrite=1 once rdy=1.
//  - lw (op=0000011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//    RegWrite=1 only in cycle 5 with ResultSrc=01.
//  - beq (funct3=000) with zero=1 -> PCWrite=1 in BRANCH, ALUOp=01.
//    bne (funct3=001) with zero=1 -> PCWrite=0.
//  - R-type -> ALUOp=10, ALUSrcB=00 in EXECUTER; I-type -> ALUSrcB=01, ImmSrc=00.
//  - mem_ready=0 for 3 cycles in FETCH -> state held, IRWrite=PCWrite=0, then DECODE one cycle after mem_ready=1.
//  - op=1111111 -> illegal_op=1 for exactly one cycle in DECODE; FETCH next; no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle RV32I main controller: opcodes, mux codes,
// state encoding and the per-state control decode.
package main_fsm_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  // fetch: IRWrite/PC update gated by rdy; decode: window for illegal_op
  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.decode    = 1'b1;
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_B)  || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, mux selects and enables out.
interface main_fsm_if #(parameter int STATE_W = 4);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               zero;
  logic               mem_ready;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               RegWrite;
  logic [1:0]         ImmSrc;
  logic [1:0]         ALUOp;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct3, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUOp, illegal_op, state
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUOp, illegal_op, state
  );
endinterface

// File: rtl/main_fsm_imm_src_dec.sv
// Immediate format select from opcode; independent of controller state.
module imm_src_dec
  import main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_B:    imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I main controller: sequences each instruction through its phases and
// drives datapath selects/enables, stalling FETCH/MEMREAD/MEMWRITE on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory ready
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | load/store address computation
// MEMREAD  | load access, waits for memory
// MEMWB    | load data into register file
// MEMWRITE | store access, strobe held until memory ready
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// JAL      | jump target into PC, return address into ALUOut
// ALUWB    | ALUOut into register file
// BRANCH   | compare; PC loads target when taken
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int STATE_W       = 4,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   rdy;
  logic   branch_ok;
  logic   branch_taken;

  assign rdy = bus.mem_ready | ~USE_MEM_READY;

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_B:         state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs are glitch-free Moore
  // decode, and reset forces the FETCH decode (dropping write strobes) asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= ctrl_decode(S_FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_decode(state_nxt);
    end
  end

  assign branch_ok    = (bus.funct3[2:1] == 2'b00);
  assign branch_taken = ctrl.branch & branch_ok & (bus.zero ^ bus.funct3[0]);

  assign bus.PCWrite    = (ctrl.fetch & rdy) | ctrl.pc_update | branch_taken;
  assign bus.IRWrite    = ctrl.fetch & rdy;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.illegal_op = ctrl.decode &
                          (~op_supported(bus.op) | ((bus.op == OP_B) & ~branch_ok));
  assign bus.state      = STATE_W'(state);

  imm_src_dec u_imm_src_dec (
    .op      (bus.op),
    .imm_src (bus.ImmSrc)
  );

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: instruction-level phase plans with randomized memory stalls,
// opcodes, funct3 and zero, plus directed reset and stall cases.
module tb_main_fsm;
  import main_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_known(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit waits(input state_t ph);
    return (ph == S_FETCH) || (ph == S_MEMREAD) || (ph == S_MEMWRITE);
  endfunction

  // Expected outputs for one phase, straight from the phase action table.
  task automatic check_phase(input state_t ph);
    logic       rdy, z, ir_e, pcw_e, adr_e, mw_e, rw_e, ill_e;
    logic [1:0] res_e, sa_e, sb_e, aop_e, imm_e;
    logic [2:0] f3;
    logic [6:0] op;
    rdy = bus.mem_ready; z = bus.zero; f3 = bus.funct3; op = bus.op;
    {ir_e, pcw_e, adr_e, mw_e, rw_e, ill_e} = '0;
    {res_e, sa_e, sb_e, aop_e} = '0;
    case (ph)
      S_FETCH:    begin sb_e = 2'b10; res_e = 2'b10; ir_e = rdy; pcw_e = rdy; end
      S_DECODE:   begin
        sa_e = 2'b01; sb_e = 2'b01;
        ill_e = !is_known(op) || (op == 7'b1100011 && f3 > 3'd1);
      end
      S_MEMADR:   begin sa_e = 2'b10; sb_e = 2'b01; end
      S_MEMREAD:  adr_e = 1'b1;
      S_MEMWB:    begin res_e = 2'b01; rw_e = 1'b1; end
      S_MEMWRITE: begin adr_e = 1'b1; mw_e = 1'b1; end
      S_EXECUTER: begin sa_e = 2'b10; aop_e = 2'b10; end
      S_EXECUTEI: begin sa_e = 2'b10; sb_e = 2'b01; aop_e = 2'b10; end
      S_JAL:      begin sa_e = 2'b01; sb_e = 2'b10; pcw_e = 1'b1; end
      S_ALUWB:    rw_e = 1'b1;
      S_BRANCH:   begin
        sa_e = 2'b10; aop_e = 2'b01;
        pcw_e = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
      end
      default: ;
    endcase
    imm_e = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
    check("state",      bus.state,      ph);
    check("PCWrite",    bus.PCWrite,    pcw_e);
    check("IRWrite",    bus.IRWrite,    ir_e);
    check("AdrSrc",     bus.AdrSrc,     adr_e);
    check("MemWrite",   bus.MemWrite,   mw_e);
    check("RegWrite",   bus.RegWrite,   rw_e);
    check("ResultSrc",  bus.ResultSrc,  res_e);
    check("ALUSrcA",    bus.ALUSrcA,    sa_e);
    check("ALUSrcB",    bus.ALUSrcB,    sb_e);
    check("ALUOp",      bus.ALUOp,      aop_e);
    check("ImmSrc",     bus.ImmSrc,     imm_e);
    check("illegal_op", bus.illegal_op, ill_e);
  endtask

  // Entered and left at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int fetch_stall, input bit rnd, input int zmode);
    state_t plan[$];
    int     idx = 0;
    int     cyc = 0;
    plan.push_back(S_FETCH);
    plan.push_back(S_DECODE);
    case (op)
      7'b0000011: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMREAD); plan.push_back(S_MEMWB); end
      7'b0100011: begin plan.push_back(S_MEMADR); plan.push_back(S_MEMWRITE); end
      7'b0110011: begin plan.push_back(S_EXECUTER); plan.push_back(S_ALUWB); end
      7'b0010011: begin plan.push_back(S_EXECUTEI); plan.push_back(S_ALUWB); end
      7'b1100011: plan.push_back(S_BRANCH);
      7'b1101111: begin plan.push_back(S_JAL); plan.push_back(S_ALUWB); end
      default: ;
    endcase
    bus.op = op;
    bus.funct3 = f3;
    while (idx < plan.size() && cyc < 100) begin
      bus.mem_ready = (cyc < fetch_stall) ? 1'b0 :
                      (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #3;
      check_phase(plan[idx]);
      if (!(waits(plan[idx]) && !bus.mem_ready)) idx++;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (idx < plan.size()) check("plan_timeout", idx, plan.size());
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 7'b0110011;
    bus.funct3 = 3'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_state",    bus.state,    S_FETCH);
    check("rst_IRWrite",  bus.IRWrite,  0);
    check("rst_PCWrite",  bus.PCWrite,  0);
    check("rst_MemWrite", bus.MemWrite, 0);
    check("rst_RegWrite", bus.RegWrite, 0);
    bus.mem_ready = 1'b1;
    #1;
    check("rst_IRWrite_rdy", bus.IRWrite, 1);
    check("rst_PCWrite_rdy", bus.PCWrite, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(7'b0000011, 3'd2, 0, 1'b0, -1);   // lw, no stall
    run_instr(7'b0100011, 3'd2, 0, 1'b0, -1);   // sw
    run_instr(7'b0110011, 3'd0, 0, 1'b0, -1);   // R-type
    run_instr(7'b0010011, 3'd0, 0, 1'b0, -1);   // I-type
    run_instr(7'b1100011, 3'd0, 0, 1'b0, 1);    // beq, zero=1: taken
    run_instr(7'b1100011, 3'd1, 0, 1'b0, 1);    // bne, zero=1: not taken
    run_instr(7'b1100011, 3'd1, 0, 1'b0, 0);    // bne, zero=0: taken
    run_instr(7'b1100011, 3'd4, 0, 1'b0, 1);    // unsupported branch sense
    run_instr(7'b1101111, 3'd0, 0, 1'b0, -1);   // jal
    run_instr(7'b1111111, 3'd0, 0, 1'b0, -1);   // illegal opcode
    run_instr(7'b0110011, 3'd0, 3, 1'b0, -1);   // 3-cycle fetch stall

    // Reset during a stalled store: strobe must drop immediately.
    bus.op = 7'b0100011;
    bus.funct3 = 3'd2;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    #2;
    check("mw_before_reset", bus.MemWrite, 1);
    check("state_before_reset", bus.state, S_MEMWRITE);
    reset = 1'b1;
    #1;
    check("mw_at_reset",    bus.MemWrite, 0);
    check("rw_at_reset",    bus.RegWrite, 0);
    check("state_at_reset", bus.state,    S_FETCH);
    check("irw_at_reset",   bus.IRWrite,  0);
    bus.mem_ready = 1'b1;
    #1;
    check("irw_reset_rdy", bus.IRWrite, 1);
    check("pcw_reset_rdy", bus.PCWrite, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      case ($urandom_range(0, 6))
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: op = 7'($urandom);
      endcase
      f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(op, f3, 0, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
